alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
Registered output stage directly downstream of the 16-bit ripple-carry ALU (AND/OR/ADD/SUB selected by S1,S0).
- Captures the ALU Result and Cout with the op select and operand sign bits.
- Derives Z/N/C/V flags, buffers up to 2 results in a FIFO, and presents them on a valid/ready interface.
- Keeps sticky carry/overflow status and a popped-result counter.

Parameters:
CNT_W, 16, width of the popped-result counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents a valid ALU result
in_ready  out  1  stage can accept (registered)
in_result  in  16  ALU Result
in_cout  in  1  ALU Cout
in_s1  in  1  op select S1 used for this result
in_s0  in  1  op select S0 used for this result
in_a_msb  in  1  A[15] of the operands
in_b_msb  in  1  B[15] of the operands (uninverted)
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_result  out  16  head result
out_flags  out  4  {Z,N,C,V} of head
sticky_c  out  1  sticky carry
sticky_v  out  1  sticky overflow
sticky_clr  in  1  clear sticky bits
result_cnt  out  CNT_W  count of popped results

Behaviour:
- Reset (async assert, sync-to-clk deassert not required):
  - FIFO count=0; out_valid=0; in_ready=1.
  - out_result=0; out_flags=0; sticky_c=0; sticky_v=0; result_cnt=0.
- Push on clk edge when in_valid&in_ready. Pop on clk edge when out_valid&out_ready.
- Flags are computed combinationally from the inputs at push time and stored with the entry:
  - Z = (in_result==0).
  - N = in_result[15].
  - C = in_cout if in_s1=1; 0 for logic ops (in_s1=0). For SUB, C=1 means no borrow.
  - V for ADD ({s1,s0}=10) = (a_msb==b_msb) & (result[15]!=a_msb).
  - V for SUB (11) = (a_msb!=b_msb) & (result[15]!=a_msb).
  - V for logic ops = 0.
- FIFO:
  - 2 entries, circular read/write pointers (1 bit each) plus a 2-bit count.
  - out_* always reflect the head entry. out_result/out_flags are don't-care when out_valid=0 but must not be X after reset.
  - Latency: push at edge k -> out_valid=1 after edge k (visible in cycle k+1) when empty.
  - in_ready = (count<2) and is a registered signal. When full, a pop at edge k raises in_ready after edge k.
  - Simultaneous push and pop with count=1: count stays 1, order preserved.
  - Pushing while full is impossible (ready low). A pop while empty is ignored.
  - Full-rate throughput is sustained with out_ready held 1.
- Sticky bits:
  - Set on push when the stored C (resp. V) = 1.
  - sticky_clr clears both bits at the clock edge.
  - Same-cycle set and clear: set wins.
- result_cnt increments on each pop and wraps from 2^CNT_W-1 to 0.
- Async reset mid-operation drops all buffered entries immediately. No partial state survives.

Optional Feature:
ALU_RESULT_PARITY_EN
- Defined:
  - Adds output out_parity (1 bit) = even parity (XOR-reduce) of out_result, stored per entry at push time.
  - Adds output parity_err (1 bit), registered, pulsing for one cycle if, on pop, the stored parity mismatches the XOR of the stored result (fault detection of storage).
  - Both outputs reset to 0.
- Not defined: the ports and storage are absent; behaviour is otherwise identical.

Test Plan:
- ADD overflow: push result=0x8000, cout=0, s=10, a_msb=0, b_msb=0 -> out_result=0x8000, flags Z0 N1 C0 V1, out_valid 1 cycle after push, sticky_v=1.
- SUB equal: push result=0x0000, cout=1, s=11, a_msb=0, b_msb=0 -> flags Z1 N0 C1 V0, sticky_c=1.
- Logic op carry masking: push result=0xFFFF, cout=1, s=01 -> flags Z0 N1 C0 V0, sticky bits unchanged.
- Backpressure: out_ready=0, push 0x0001, 0x0002 -> in_ready=0 after 2nd push. Then out_ready=1 -> pops 0x0001 then 0x0002 in order, in_ready=1 after first pop, result_cnt=2.
- Simultaneous: with count=1, push and pop same cycle for 4 cycles -> count stays 1, 4 pops counted; sticky_clr asserted on a V=1 push cycle -> sticky_v remains 1.
- Reset mid-operation: 2 entries buffered, rst_n low asynchronously -> out_valid=0, in_ready=1, result_cnt=0, sticky bits 0 before next clk edge.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if
// Signal bundle between the ALU result stage and its neighbours.
//   master : upstream ALU / downstream consumer / status reader (testbench side)
//   slave  : alu_result_stage itself
// Upstream   : in_valid, in_ready, in_result, in_cout, in_s1, in_s0,
//              in_a_msb, in_b_msb
// Downstream : out_valid, out_ready, out_result, out_flags {Z,N,C,V}
// Status     : sticky_c, sticky_v, sticky_clr, result_cnt
// Optional (macro ALU_RESULT_PARITY_EN): out_parity, parity_err
// ---------------------------------------------------------------------------
interface alu_result_stage_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_result;
  logic             in_cout;
  logic             in_s1;
  logic             in_s0;
  logic             in_a_msb;
  logic             in_b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic [3:0]       out_flags;
  logic             sticky_c;
  logic             sticky_v;
  logic             sticky_clr;
  logic [CNT_W-1:0] result_cnt;
`ifdef ALU_RESULT_PARITY_EN
  logic             out_parity;
  logic             parity_err;
`endif

  modport master (
    output in_valid, in_result, in_cout, in_s1, in_s0, in_a_msb, in_b_msb,
    output out_ready, sticky_clr,
    input  in_ready, out_valid, out_result, out_flags,
    input  sticky_c, sticky_v, result_cnt
`ifdef ALU_RESULT_PARITY_EN
    , input out_parity, parity_err
`endif
  );

  modport slave (
    input  in_valid, in_result, in_cout, in_s1, in_s0, in_a_msb, in_b_msb,
    input  out_ready, sticky_clr,
    output in_ready, out_valid, out_result, out_flags,
    output sticky_c, sticky_v, result_cnt
`ifdef ALU_RESULT_PARITY_EN
    , output out_parity, parity_err
`endif
  );
endinterface

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
// Registered output stage behind the 16-bit ALU. Each accepted result is
// stored with its {Z,N,C,V} flags in a 2-entry FIFO and presented on a
// valid/ready output. Sticky carry/overflow and a popped-result counter
// (wraps modulo 2^CNT_W) are maintained alongside.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_result_stage_if.slave (handshakes, data, flags, status)
// Optional feature macro ALU_RESULT_PARITY_EN: stores even parity per entry,
// drives bus.out_parity and a one-cycle bus.parity_err pulse on a pop whose
// stored parity disagrees with the stored result.
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_result_stage_if.slave bus
);
  logic [15:0]      r_result [2];
  logic [3:0]       r_flags  [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             r_in_ready;
  logic             r_sticky_c;
  logic             r_sticky_v;
  logic [CNT_W-1:0] r_cnt;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;
  logic             w_z;
  logic             w_n;
  logic             w_c;
  logic             w_v;

  // in_ready is registered, so it alone gates pushes; no full check needed here
  assign w_push = bus.in_valid & r_in_ready;
  assign w_pop  = (r_count != 2'd0) & bus.out_ready;

  always_comb begin
    w_z = (bus.in_result == 16'h0000);
    w_n = bus.in_result[15];
    w_c = 1'b0;
    w_v = 1'b0;
    case ({bus.in_s1, bus.in_s0})
      2'b10: begin
        w_c = bus.in_cout;
        w_v = (bus.in_a_msb == bus.in_b_msb) & (bus.in_result[15] != bus.in_a_msb);
      end
      2'b11: begin
        // C=1 means no borrow; b_msb is the uninverted operand
        w_c = bus.in_cout;
        w_v = (bus.in_a_msb != bus.in_b_msb) & (bus.in_result[15] != bus.in_a_msb);
      end
      default: begin
        w_c = 1'b0;
        w_v = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_result[i] <= 16'h0000;
        r_flags[i]  <= 4'h0;
      end
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
      r_sticky_c <= 1'b0;
      r_sticky_v <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_push) begin
        r_result[r_wptr] <= bus.in_result;
        r_flags[r_wptr]  <= {w_z, w_n, w_c, w_v};
        r_wptr           <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
      // a set in the same cycle as a clear wins
      r_sticky_c <= (r_sticky_c & ~bus.sticky_clr) | (w_push & w_c);
      r_sticky_v <= (r_sticky_v & ~bus.sticky_clr) | (w_push & w_v);
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = (r_count != 2'd0);
  assign bus.out_result = r_result[r_rptr];
  assign bus.out_flags  = r_flags[r_rptr];
  assign bus.sticky_c   = r_sticky_c;
  assign bus.sticky_v   = r_sticky_v;
  assign bus.result_cnt = r_cnt;

`ifdef ALU_RESULT_PARITY_EN
  logic r_par [2];
  logic r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par[0]     <= 1'b0;
      r_par[1]     <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_par[r_wptr] <= ^bus.in_result;
      end
      r_parity_err <= w_pop & (r_par[r_rptr] != ^r_result[r_rptr]);
    end
  end

  assign bus.out_parity = r_par[r_rptr];
  assign bus.parity_err = r_parity_err;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_stage_if #(.CNT_W(CNT_W)) bus ();
  alu_result_stage #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // called at posedge+1; expected flags {Z,N,C,V} are hand-computed by caller
  task automatic push(input logic [15:0] r, input logic c, input logic s1, input logic s0,
                      input logic a, input logic b, input logic [3:0] ef);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_result = r;
    bus.in_cout   = c;
    bus.in_s1     = s1;
    bus.in_s0     = s0;
    bus.in_a_msb  = a;
    bus.in_b_msb  = b;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      chk("push_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
    end else begin
      @(posedge clk);
      sb.push_back({r, ef});
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_result", 32'(bus.out_result), 32'(e.res));
          chk("out_flags", 32'(bus.out_flags), 32'(e.flg));
        end
      end
    end
  end

  initial begin : stim
    bus.in_valid = 0; bus.in_result = 0; bus.in_cout = 0; bus.in_s1 = 0; bus.in_s0 = 0;
    bus.in_a_msb = 0; bus.in_b_msb = 0; bus.out_ready = 0; bus.sticky_clr = 0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_result", 32'(bus.out_result), 32'd0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
    chk("rst_sticky", 32'({bus.sticky_c, bus.sticky_v}), 32'd0);
    chk("rst_cnt", 32'(bus.result_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow
    push(16'h8000, 0, 1, 0, 0, 0, 4'b0101);
    @(negedge clk);
    chk("add_latency_valid", 32'(bus.out_valid), 32'd1);
    chk("add_sticky_v", 32'(bus.sticky_v), 32'd1);
    chk("add_sticky_c", 32'(bus.sticky_c), 32'd0);
    @(posedge clk); #1; drain();

    // SUB equal operands
    push(16'h0000, 1, 1, 1, 0, 0, 4'b1010);
    @(negedge clk);
    chk("sub_sticky_c", 32'(bus.sticky_c), 32'd1);
    @(posedge clk); #1; drain();

    bus.sticky_clr = 1'b1;
    @(posedge clk); #1;
    bus.sticky_clr = 1'b0;
    chk("clr_sticky", 32'({bus.sticky_c, bus.sticky_v}), 32'd0);

    // logic op masks carry
    push(16'hFFFF, 1, 0, 1, 0, 0, 4'b0100);
    @(negedge clk);
    chk("logic_sticky", 32'({bus.sticky_c, bus.sticky_v}), 32'd0);
    @(posedge clk); #1; drain();

    // SUB overflow, ADD carry+overflow to zero
    push(16'h7FFF, 1, 1, 1, 1, 0, 4'b0011);
    push(16'h0000, 1, 1, 0, 1, 1, 4'b1011);
    drain();
    chk("cnt_5", 32'(bus.result_cnt), 32'd5);

    // backpressure
    push(16'h0001, 0, 0, 0, 0, 0, 4'b0000);
    push(16'h0002, 0, 0, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pop_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("cnt_7", 32'(bus.result_cnt), 32'd7);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // simultaneous push/pop at count=1, with set-wins sticky check
    bus.sticky_clr = 1'b1;
    @(posedge clk); #1;
    bus.sticky_clr = 1'b0;
    chk("clr2_sticky", 32'({bus.sticky_c, bus.sticky_v}), 32'd0);
    push(16'h00AA, 0, 0, 0, 0, 0, 4'b0000);
    bus.out_ready = 1'b1;
    push(16'h0010, 0, 0, 0, 0, 0, 4'b0000);
    bus.sticky_clr = 1'b1;
    push(16'h8001, 0, 1, 0, 0, 0, 4'b0101);
    bus.sticky_clr = 1'b0;
    chk("setwins_sticky_v", 32'(bus.sticky_v), 32'd1);
    chk("setwins_sticky_c", 32'(bus.sticky_c), 32'd0);
    push(16'h1234, 0, 0, 1, 0, 0, 4'b0000);
    push(16'hFFFE, 0, 1, 1, 1, 1, 4'b0100);
    @(negedge clk);
    chk("simul_valid", 32'(bus.out_valid), 32'd1);
    chk("simul_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1; drain();
    chk("cnt_12", 32'(bus.result_cnt), 32'd12);

    // full-rate stream, counter wraps past 15
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(16'(i + 1), 0, 0, 0, 0, 0, 4'b0000);
    drain();
    chk("cnt_wrap", 32'(bus.result_cnt), 32'd1);

    // async reset with two entries buffered
    push(16'h0000, 1, 1, 1, 0, 0, 4'b1010);
    push(16'h0005, 1, 1, 1, 0, 0, 4'b0010);
    @(negedge clk);
    chk("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("pre_rst_sticky_c", 32'(bus.sticky_c), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_cnt", 32'(bus.result_cnt), 32'd0);
    chk("mid_rst_sticky", 32'({bus.sticky_c, bus.sticky_v}), 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    push(16'h4321, 0, 0, 0, 0, 0, 4'b0000);
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1; drain();
    chk("post_rst_cnt", 32'(bus.result_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
